// File: rtl/spi_master_burst_if.sv
// Word handshake and SPI pin bundle for the burst SPI master.
// The agent drives the master modport; the SPI master uses the slave modport.
interface spi_master_burst_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [DATA_W-1:0] i_TX_Word;
    logic              i_TX_DV;
    logic              o_TX_Ready;
    logic [CS_W-1:0]   i_CS_Sel;
    logic [7:0]        i_Burst_Len;
    logic              o_RX_DV;
    logic [DATA_W-1:0] o_RX_Word;
    logic              o_SPI_Clk;
    logic              o_SPI_MOSI;
    logic              i_SPI_MISO;
    logic [NUM_CS-1:0] o_SPI_CS_n;

    modport master (
        output i_TX_Word, i_TX_DV, i_CS_Sel, i_Burst_Len, i_SPI_MISO,
        input  o_TX_Ready, o_RX_DV, o_RX_Word,
        input  o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

    modport slave (
        input  i_TX_Word, i_TX_DV, i_CS_Sel, i_Burst_Len, i_SPI_MISO,
        output o_TX_Ready, o_RX_DV, o_RX_Word,
        output o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_master_burst.sv
// Single-clock SPI master with configurable mode, width, divider and
// multi-word bursts held under one chip-select assertion.
module spi_master_burst #(
    parameter int DATA_W            = 8,
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int NUM_CS            = 1,
    parameter int CS_GAP_CLKS       = 2
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    spi_master_burst_if.slave   bus
);
    localparam logic CPOL    = 1'((SPI_MODE >> 1) & 1);
    localparam logic CPHA    = 1'(SPI_MODE & 1);
    localparam int   EDGES   = 2 * DATA_W;
    localparam int   EW      = $clog2(EDGES + 1);
    localparam int   CNT_MAX = (CLKS_PER_HALF_BIT > CS_GAP_CLKS) ?
                               CLKS_PER_HALF_BIT : CS_GAP_CLKS;
    localparam int   CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        XFER,
        WAIT_NEXT,
        CS_HOLD,
        CS_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [7:0]        left_q, left_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              rx_dv_q, rx_dv_d;

    logic              accept;
    logic              last_half;
    logic              xfer_done;
    logic              do_edge;
    logic              lead;
    logic [NUM_CS-1:0] cs_dec;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            left_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_word_q <= '0;
            cs_n_q    <= '1;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b0;
            rx_dv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            left_q    <= left_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_word_q <= rx_word_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

    // An out-of-range select decodes to all ones: the burst runs unselected.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (int'(bus.i_CS_Sel) != i);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        left_d    = left_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_word_d = rx_word_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ready_d   = ready_q;
        rx_dv_d   = 1'b0;

        accept    = bus.i_TX_DV && ready_q;
        last_half = (cnt_q == CW'(CLKS_PER_HALF_BIT - 1));
        xfer_done = (edge_q == EW'(EDGES));
        do_edge   = last_half &&
                    ((state_q == CS_SETUP) ||
                     ((state_q == XFER) && !xfer_done));
        lead      = !edge_q[0];

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    state_d = CS_SETUP;
                    tx_d    = bus.i_TX_Word;
                    mosi_d  = bus.i_TX_Word[DATA_W-1];
                    cnt_d   = '0;
                    edge_d  = '0;
                    ready_d = 1'b0;
                    cs_n_d  = cs_dec;
                    left_d  = (bus.i_Burst_Len == 8'd0) ?
                              8'd1 : bus.i_Burst_Len;
                end
            end
            CS_SETUP: begin
                if (last_half) state_d = XFER;
                else           cnt_d   = cnt_q + CW'(1);
            end
            XFER: begin
                if (xfer_done) begin
                    rx_dv_d   = 1'b1;
                    rx_word_d = rx_q;
                    left_d    = left_q - 8'd1;
                    cnt_d     = '0;
                    edge_d    = '0;
                    if (left_q > 8'd1) begin
                        state_d = WAIT_NEXT;
                        ready_d = 1'b1;
                    end else begin
                        state_d = CS_HOLD;
                    end
                end else if (!last_half) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_NEXT: begin
                if (accept) begin
                    state_d = CS_SETUP;
                    tx_d    = bus.i_TX_Word;
                    mosi_d  = bus.i_TX_Word[DATA_W-1];
                    cnt_d   = '0;
                    edge_d  = '0;
                    ready_d = 1'b0;
                end
            end
            CS_HOLD: begin
                if (last_half) begin
                    state_d = CS_GAP;
                    cs_n_d  = '1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CS_GAP: begin
                if (cnt_q == CW'(CS_GAP_CLKS - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Even edge count means the next SCLK transition is a leading edge.
        if (do_edge) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + EW'(1);
            cnt_d  = '0;
            if (!CPHA) begin
                if (lead) begin
                    rx_d = {rx_q[DATA_W-2:0], bus.i_SPI_MISO};
                end else if (edge_q != EW'(EDGES - 1)) begin
                    mosi_d = tx_q[DATA_W-2];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                if (lead) begin
                    mosi_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end else begin
                    rx_d = {rx_q[DATA_W-2:0], bus.i_SPI_MISO};
                end
            end
        end
    end

    assign bus.o_TX_Ready = ready_q;
    assign bus.o_RX_DV    = rx_dv_q;
    assign bus.o_RX_Word  = rx_word_q;
    assign bus.o_SPI_Clk  = sclk_q;
    assign bus.o_SPI_MOSI = mosi_q;
    assign bus.o_SPI_CS_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_burst.sv
// Directed and randomized checks of spi_master_burst in three
// configurations against a behavioural SPI slave and word scoreboard.
module tb_spi_master_burst;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic mid_n;
    logic rst0_n;
    assign rst0_n = rst_n & mid_n;

    int checks = 0;
    int errors = 0;

    spi_master_burst_if #(.DATA_W(8),  .NUM_CS(3)) b0 ();
    spi_master_burst_if #(.DATA_W(8),  .NUM_CS(1)) b1 ();
    spi_master_burst_if #(.DATA_W(16), .NUM_CS(4)) b2 ();

    spi_master_burst #(
        .DATA_W(8), .SPI_MODE(0), .CLKS_PER_HALF_BIT(2),
        .NUM_CS(3), .CS_GAP_CLKS(2)
    ) u0 (.i_Clk(clk), .i_Rst_L(rst0_n), .bus(b0));

    spi_master_burst #(
        .DATA_W(8), .SPI_MODE(3), .CLKS_PER_HALF_BIT(2),
        .NUM_CS(1), .CS_GAP_CLKS(2)
    ) u1 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(b1));

    spi_master_burst #(
        .DATA_W(16), .SPI_MODE(1), .CLKS_PER_HALF_BIT(3),
        .NUM_CS(4), .CS_GAP_CLKS(3)
    ) u2 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(b2));

    logic [31:0] t_word [3];
    logic        t_dv   [3];
    logic [2:0]  t_sel  [3];
    logic [7:0]  t_bl   [3];
    logic        miso_v [3];

    assign b0.i_TX_Word   = t_word[0][7:0];
    assign b1.i_TX_Word   = t_word[1][7:0];
    assign b2.i_TX_Word   = t_word[2][15:0];
    assign b0.i_TX_DV     = t_dv[0];
    assign b1.i_TX_DV     = t_dv[1];
    assign b2.i_TX_DV     = t_dv[2];
    assign b0.i_CS_Sel    = t_sel[0][1:0];
    assign b1.i_CS_Sel    = t_sel[1][0];
    assign b2.i_CS_Sel    = t_sel[2][1:0];
    assign b0.i_Burst_Len = t_bl[0];
    assign b1.i_Burst_Len = t_bl[1];
    assign b2.i_Burst_Len = t_bl[2];
    assign b0.i_SPI_MISO  = b0.o_SPI_MOSI;
    assign b1.i_SPI_MISO  = miso_v[1];
    assign b2.i_SPI_MISO  = miso_v[2];

    logic rdy [3];
    logic csall [3];
    assign rdy[0]   = b0.o_TX_Ready;
    assign rdy[1]   = b1.o_TX_Ready;
    assign rdy[2]   = b2.o_TX_Ready;
    assign csall[0] = &b0.o_SPI_CS_n;
    assign csall[1] = &b1.o_SPI_CS_n;
    assign csall[2] = &b2.o_SPI_CS_n;

    // Slave model: captures MOSI on the sampling edge of the mode and
    // always presents the next bit of its own word on MISO.
    logic [31:0] sl_w  [3][64];
    logic [31:0] cap_w [3][64];
    logic [31:0] rx_w  [3][64];
    logic [31:0] cap   [3];
    int          bitcnt [3] = '{0, 0, 0};
    int          cap_n  [3] = '{0, 0, 0};
    int          rx_n   [3] = '{0, 0, 0};
    logic        psclk  [3];

    task automatic mon(input int m, input int w, input logic cpol,
                       input logic cpha, input logic rst, input logic sclk,
                       input logic mosi, input logic dv,
                       input logic [31:0] rw);
        if (dv === 1'b1) begin
            rx_w[m][rx_n[m] % 64] = rw;
            rx_n[m]++;
        end
        if (rst !== 1'b1) begin
            bitcnt[m] = 0;
        end else if (sclk !== psclk[m] && ((sclk != cpol) == !cpha)) begin
            cap[m] = {cap[m][30:0], mosi};
            bitcnt[m]++;
            if (bitcnt[m] == w) begin
                cap_w[m][cap_n[m] % 64] = cap[m] & ((32'd1 << w) - 32'd1);
                cap_n[m]++;
                bitcnt[m] = 0;
            end
        end
        psclk[m]  = sclk;
        miso_v[m] = sl_w[m][cap_n[m] % 64][w - 1 - bitcnt[m]];
    endtask

    always @(negedge clk) begin
        mon(0, 8, 1'b0, 1'b0, rst0_n, b0.o_SPI_Clk, b0.o_SPI_MOSI,
            b0.o_RX_DV, 32'(b0.o_RX_Word));
        mon(1, 8, 1'b1, 1'b1, rst_n, b1.o_SPI_Clk, b1.o_SPI_MOSI,
            b1.o_RX_DV, 32'(b1.o_RX_Word));
        mon(2, 16, 1'b0, 1'b1, rst_n, b2.o_SPI_Clk, b2.o_SPI_MOSI,
            b2.o_RX_DV, 32'(b2.o_RX_Word));
    end

    logic watch2 = 1'b0;
    int   cs2_bad = 0;
    always @(negedge clk) begin
        if (watch2 && b2.o_SPI_CS_n !== 4'b1011) cs2_bad++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int m, input logic [31:0] wd,
                        input int sel, input int bl);
        int n = 0;
        t_word[m] = wd;
        t_sel[m]  = 3'(sel);
        t_bl[m]   = 8'(bl);
        t_dv[m]   = 1'b1;
        while (rdy[m] !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        checks++;
        assert (rdy[m] === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout%0d obs=%0b exp=1", m, rdy[m]);
        end
        @(posedge clk);
        step();
        t_dv[m] = 1'b0;
    endtask

    task automatic wait_rx(input int m, input int target,
                           output bit lowseen);
        int n = 0;
        lowseen = 1'b0;
        while (rx_n[m] < target && n < 600) begin
            step();
            n++;
            if (csall[m] === 1'b0) lowseen = 1'b1;
        end
        checks++;
        assert (rx_n[m] >= target) else begin
            errors++;
            $error("FAIL rx_timeout%0d obs=%0d exp=%0d", m, rx_n[m], target);
        end
    endtask

    logic sk [41];
    logic ck [41];
    logic dk [41];
    logic rk [41];

    initial begin
        int base, cb, nch, first, last, ndv, dvpos, lows, e, n, blen;
        logic prev;
        bit low;
        logic [31:0] wd [3];
        logic [31:0] w16 [3];

        rst_n = 1'b0;
        mid_n = 1'b1;
        for (int m = 0; m < 3; m++) begin
            t_dv[m] = 1'b0; t_word[m] = '0; t_sel[m] = '0; t_bl[m] = 8'd1;
            for (int i = 0; i < 64; i++) sl_w[m][i] = '0;
        end
        repeat (3) step();

        chk("rst_ready0", b0.o_TX_Ready, 0);
        chk("rst_rxdv0", b0.o_RX_DV, 0);
        chk("rst_rxword0", b0.o_RX_Word, 0);
        chk("rst_sclk0", b0.o_SPI_Clk, 0);
        chk("rst_mosi0", b0.o_SPI_MOSI, 0);
        chk("rst_cs0", b0.o_SPI_CS_n, 3'b111);
        chk("rst_sclk1", b1.o_SPI_Clk, 1);
        chk("rst_cs2", b2.o_SPI_CS_n, 4'hF);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst0", b0.o_TX_Ready, 1);
        chk("ready_after_rst1", b1.o_TX_Ready, 1);
        chk("ready_after_rst2", b2.o_TX_Ready, 1);

        // Mode 0 loopback timing of a single 0xA5 word.
        base = rx_n[0]; cb = cap_n[0];
        sk[0] = b0.o_SPI_Clk;
        send(0, 32'hA5, 0, 1);
        for (int k = 1; k <= 40; k++) begin
            sk[k] = b0.o_SPI_Clk; ck[k] = b0.o_SPI_CS_n[0];
            dk[k] = b0.o_RX_DV;   rk[k] = b0.o_TX_Ready;
            step();
        end
        nch = 0; first = 0; last = 0; ndv = 0; dvpos = 0; lows = 0;
        for (int k = 1; k <= 40; k++) begin
            if (sk[k] != sk[k-1]) begin
                nch++;
                if (first == 0) first = k;
                last = k;
            end
            if (dk[k]) begin ndv++; dvpos = k; end
            if (!ck[k]) lows++;
        end
        chk("a5_sclk_edges", nch, 16);
        chk("a5_first_edge", first, 3);
        chk("a5_last_edge", last, 33);
        chk("a5_dv_count", ndv, 1);
        chk("a5_dv_cycle", dvpos, 34);
        chk("a5_cs_first", ck[1], 0);
        chk("a5_cs_low_cycles", lows, 35);
        chk("a5_cs_release", ck[36], 1);
        chk("a5_ready_gap", rk[37], 0);
        chk("a5_ready_back", rk[38], 1);
        chk("a5_rx_word", rx_w[0][base], 32'hA5);
        chk("a5_mosi_bits", cap_w[0][cb], 32'hA5);

        // Mode 3 with the slave returning 0x3C.
        base = rx_n[1]; cb = cap_n[1];
        chk("m3_idle_sclk", b1.o_SPI_Clk, 1);
        sl_w[1][cb % 64] = 32'h3C;
        send(1, 32'hFF, 0, 1);
        wait_rx(1, base + 1, low);
        chk("m3_rx_word", rx_w[1][base % 64], 32'h3C);
        chk("m3_slave_sample", cap_w[1][cb % 64], 32'hFF);
        chk("m3_cs_low", low, 1);
        repeat (8) step();
        chk("m3_idle_after", b1.o_SPI_Clk, 1);

        // 16-bit burst of three words on chip select 2.
        base = rx_n[2]; cb = cap_n[2];
        w16[0] = 32'h1234; w16[1] = 32'hBEEF; w16[2] = 32'h0001;
        for (int i = 0; i < 3; i++) sl_w[2][(cb + i) % 64] = $urandom & 32'hFFFF;
        send(2, w16[0], 2, 3);
        watch2 = 1'b1;
        send(2, w16[1], 1, 0);
        send(2, w16[2], 3, 0);
        wait_rx(2, base + 3, low);
        watch2 = 1'b0;
        chk("burst_cs_steady", cs2_bad, 0);
        chk("burst_dv_pulses", rx_n[2] - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk("burst_rx", rx_w[2][(base + i) % 64], sl_w[2][(cb + i) % 64]);
            chk("burst_mosi", cap_w[2][(cb + i) % 64], w16[i]);
        end
        step(); step();
        chk("burst_cs_hold", b2.o_SPI_CS_n, 4'b1011);
        step();
        chk("burst_cs_off", b2.o_SPI_CS_n, 4'hF);

        // Valid pulse during a transfer is dropped.
        base = rx_n[0]; cb = cap_n[0];
        wd[0] = $urandom & 32'hFF;
        send(0, wd[0], 1, 1);
        repeat (6) step();
        t_word[0] = 32'h55; t_dv[0] = 1'b1;
        step();
        t_dv[0] = 1'b0;
        wait_rx(0, base + 1, low);
        chk("drop_rx", rx_w[0][base % 64], wd[0]);
        chk("drop_mosi", cap_w[0][cb % 64], wd[0]);
        repeat (60) step();
        chk("drop_no_extra_rx", rx_n[0] - base, 1);
        chk("drop_no_extra_xfer", cap_n[0] - cb, 1);

        // Reset landing on the fourth SCLK edge of a word.
        base = rx_n[0];
        send(0, 32'h96, 1, 1);
        prev = b0.o_SPI_Clk; e = 0; n = 0;
        while (e < 3 && n < 200) begin
            step(); n++;
            if (b0.o_SPI_Clk != prev) begin e++; prev = b0.o_SPI_Clk; end
        end
        chk("mid_edges_seen", e, 3);
        step();
        mid_n = 1'b0;
        step();
        chk("mid_cs", b0.o_SPI_CS_n, 3'b111);
        chk("mid_sclk", b0.o_SPI_Clk, 0);
        chk("mid_ready", b0.o_TX_Ready, 0);
        chk("mid_rxdv", b0.o_RX_DV, 0);
        mid_n = 1'b1;
        step();
        chk("mid_ready_back", b0.o_TX_Ready, 1);
        chk("mid_no_rx", rx_n[0] - base, 0);
        cb = cap_n[0];
        send(0, 32'hC3, 2, 1);
        wait_rx(0, base + 1, low);
        chk("c3_rx", rx_w[0][base % 64], 32'hC3);
        chk("c3_mosi", cap_w[0][cb % 64], 32'hC3);
        chk("c3_cs_low", low, 1);

        // Out-of-range select with a zero burst length.
        repeat (10) step();
        base = rx_n[0]; cb = cap_n[0];
        send(0, 32'h81, 3, 0);
        wait_rx(0, base + 1, low);
        chk("oor_cs_never_low", low, 0);
        chk("oor_rx", rx_w[0][base % 64], 32'h81);
        chk("oor_mosi", cap_w[0][cb % 64], 32'h81);
        repeat (60) step();
        chk("oor_one_word", cap_n[0] - cb, 1);
        chk("oor_one_dv", rx_n[0] - base, 1);
        chk("oor_ready", b0.o_TX_Ready, 1);

        // Randomized bursts in mode 0 loopback and mode 1.
        for (int it = 0; it < 3; it++) begin
            base = rx_n[0]; cb = cap_n[0];
            blen = $urandom_range(1, 3);
            for (int j = 0; j < blen; j++) begin
                wd[j] = $urandom & 32'hFF;
                send(0, wd[j], $urandom_range(0, 2), blen);
            end
            wait_rx(0, base + blen, low);
            chk("rnd0_cs_low", low, 1);
            for (int j = 0; j < blen; j++) begin
                chk("rnd0_rx", rx_w[0][(base + j) % 64], wd[j]);
                chk("rnd0_mosi", cap_w[0][(cb + j) % 64], wd[j]);
            end
        end
        for (int it = 0; it < 2; it++) begin
            base = rx_n[2]; cb = cap_n[2];
            for (int j = 0; j < 2; j++) begin
                wd[j] = $urandom & 32'hFFFF;
                sl_w[2][(cb + j) % 64] = $urandom & 32'hFFFF;
            end
            send(2, wd[0], $urandom_range(0, 3), 2);
            send(2, wd[1], 0, 1);
            wait_rx(2, base + 2, low);
            for (int j = 0; j < 2; j++) begin
                chk("rnd2_rx", rx_w[2][(base + j) % 64], sl_w[2][(cb + j) % 64]);
                chk("rnd2_mosi", cap_w[2][(cb + j) % 64], wd[j]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
